// File: rtl/dequeue_mux_pkg.sv
// ----------------------------------------------------------------------------
// dequeue_mux_pkg
//   Shared definitions for the dequeue mux slice: queue count, queue-id width,
//   FSM state encoding and a one-hot helper for the pop strobe.
// ----------------------------------------------------------------------------
package dequeue_mux_pkg;

    localparam int NUM_Q = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // One-hot decode of a queue id.
    function automatic logic [NUM_Q-1:0] id_onehot(input logic [ID_W-1:0] qid);
        return NUM_Q'(1) << qid;
    endfunction

endpackage

// File: rtl/dequeue_mux_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   CNT_W-bit up counter that increments by one on each cycle inc is high and
//   sticks at all-ones instead of wrapping.
// Ports:
//   clk      in   rising-edge clock
//   reset_L  in   asynchronous active-low reset (count -> 0)
//   inc      in   increment request for this cycle
//   count    out  current count value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/dequeue_mux.sv
// ----------------------------------------------------------------------------
// dequeue_mux
//   Downstream stage of the round-robin arbiter. Pops the input FIFO chosen by
//   id, muxes its read data into one registered output stream and keeps a
//   saturating pop counter per queue.
// Ports:
//   clk              in   rising-edge clock
//   reset_L          in   asynchronous active-low reset
//   id               in   queue selected by the arbiter this cycle
//   empty            in   per-FIFO empty flags (bit n = queue n)
//   data_in0..3      in   FIFO read data, valid the cycle after pop
//   out_almost_full  in   downstream back-pressure
//   pop              out  one-hot read strobe to the input FIFOs
//   data_out         out  registered output word
//   valid_out        out  data_out is new this cycle (push downstream)
//   idle             out  FSM in IDLE with nothing in flight
//   pop_count        out  per-queue pop counters, queue n at [n*CNT_W +: CNT_W]
//
// Handshake: pop is a single-cycle read strobe with no acknowledge; valid_out
// is a push with no ready. Back-pressure is out_almost_full only: it gates new
// pops, and the up to two words already in the pipe still emerge, so the
// downstream threshold must leave at least two free entries.
// ----------------------------------------------------------------------------
import dequeue_mux_pkg::*;

module dequeue_mux #(
    parameter int DATA_W      = 6,
    parameter int CNT_W       = 8,
    parameter int INIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [ID_W-1:0]        id,
    input  logic [NUM_Q-1:0]       empty,
    input  logic [DATA_W-1:0]      data_in0,
    input  logic [DATA_W-1:0]      data_in1,
    input  logic [DATA_W-1:0]      data_in2,
    input  logic [DATA_W-1:0]      data_in3,
    input  logic                   out_almost_full,
    output logic [NUM_Q-1:0]       pop,
    output logic [DATA_W-1:0]      data_out,
    output logic                   valid_out,
    output logic                   idle,
    output logic [NUM_Q*CNT_W-1:0] pop_count
);

    // INIT_CYCLES of 0 behaves as 1: the counter needs at least one cycle.
    localparam int INIT_LAST = (INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0;
    localparam int INIT_W    = (INIT_LAST > 0) ? $clog2(INIT_LAST + 1) : 1;

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [ID_W-1:0]     sel_q, sel_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;

    logic [NUM_Q-1:0]    pop_w;
    logic [DATA_W-1:0]   rd_data [NUM_Q];

    assign rd_data[0] = data_in0;
    assign rd_data[1] = data_in1;
    assign rd_data[2] = data_in2;
    assign rd_data[3] = data_in3;

    // A skipped (empty) selection is not retried; the arbiter simply moves on.
    always_comb begin
        pop_w = '0;
        if ((state_q == ST_ACTIVE) && !empty[id] && !out_almost_full) begin
            pop_w = id_onehot(id);
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q >= INIT_W'(INIT_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            ST_IDLE: begin
                if (empty != {NUM_Q{1'b1}}) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Leave only once both pipeline stages have drained.
                if ((empty == {NUM_Q{1'b1}}) && !pend_q && !valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Stage 1 remembers which FIFO was popped; stage 2 captures its data
        // one cycle later, when the FIFO presents it.
        sel_d   = id;
        pend_d  = |pop_w;
        data_d  = pend_q ? rd_data[sel_q] : data_q;
        valid_d = pend_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            sel_q      <= '0;
            pend_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sel_q      <= sel_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    for (genvar n = 0; n < NUM_Q; n++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_L (reset_L),
            .inc     (pop_w[n]),
            .count   (pop_count[n*CNT_W +: CNT_W])
        );
    end

    assign pop       = pop_w;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign idle      = (state_q == ST_IDLE);

endmodule

// File: tb/tb_dequeue_mux.sv
// ----------------------------------------------------------------------------
// tb_dequeue_mux
//   Directed bench for dequeue_mux. Behavioural input FIFOs supply data one
//   cycle after each pop; a reference model predicts pop/idle/counters and a
//   scoreboard queue holds each expected word with the cycle it must appear.
// ----------------------------------------------------------------------------
module tb_dequeue_mux;
  import dequeue_mux_pkg::*;

  localparam int DATA_W      = 6;
  localparam int CNT_W       = 8;
  localparam int INIT_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_L;
  logic [1:0]             id;
  logic [3:0]             empty;
  logic [DATA_W-1:0]      din [4];
  logic                   af;
  logic [3:0]             pop;
  logic [DATA_W-1:0]      data_out;
  logic                   valid_out;
  logic                   idle;
  logic [4*CNT_W-1:0]     pop_count;

  dequeue_mux #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .INIT_CYCLES (INIT_CYCLES)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .id              (id),
    .empty           (empty),
    .data_in0        (din[0]),
    .data_in1        (din[1]),
    .data_in2        (din[2]),
    .data_in3        (din[3]),
    .out_almost_full (af),
    .pop             (pop),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .idle            (idle),
    .pop_count       (pop_count)
  );

  // ---------------- FIFO model and reference state ----------------
  int               rem [4];
  int               rd_idx [4];
  logic [DATA_W-1:0] base [4];
  logic [3:0]       force_e;

  assign empty[0] = (rem[0] == 0) || force_e[0];
  assign empty[1] = (rem[1] == 0) || force_e[1];
  assign empty[2] = (rem[2] == 0) || force_e[2];
  assign empty[3] = (rem[3] == 0) || force_e[3];

  int               m_state;
  int               m_init;
  int               m_cnt [4];
  int               cycle_no;
  logic [3:0]       last_pop;
  logic [3:0]       last_dut_pop;
  int               vcount;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q [$];
  int                exp_cyc_q [$];
  logic [DATA_W-1:0] seen_q [$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_init  = 0;
    cycle_no = 0;
    last_pop = '0;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int n = 0; n < 4; n++) begin
      m_cnt[n]  = 0;
      rem[n]    = 0;
      rd_idx[n] = 0;
      din[n]    = '0;
    end
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // then update the FIFO read data just after the rising edge.
  task automatic step();
    logic [3:0] mp;
    logic       inflight;
    @(negedge clk);
    last_dut_pop = pop;
    if (!reset_L) begin
      chk("rst_pop", pop, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_idle", idle, 0);
      chk("rst_count", pop_count, 0);
      mp = '0;
    end else begin
      inflight = (exp_cyc_q.size() != 0);
      mp = ((m_state == 2) && !empty[id] && !af) ? 4'(1 << id) : 4'b0;
      chk("pop", pop, mp);
      chk("idle", idle, (m_state == 1));
      if ((exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cycle_no)) begin
        chk("valid", valid_out, 1);
        chk("data", data_out, exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        seen_q.push_back(data_out);
        vcount++;
      end else begin
        chk("no_valid", valid_out, 0);
      end
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("count%0d", n), pop_count[n*CNT_W +: CNT_W], m_cnt[n]);
      end
      if (mp != 0) begin
        exp_q.push_back(base[id] + DATA_W'(rd_idx[id]));
        exp_cyc_q.push_back(cycle_no + 2);
      end
      case (m_state)
        0: if (m_init >= INIT_CYCLES - 1) m_state = 1; else m_init++;
        1: if (empty != 4'hF) m_state = 2;
        default: if ((empty == 4'hF) && !inflight) m_state = 1;
      endcase
      for (int n = 0; n < 4; n++) begin
        if (mp[n] && (m_cnt[n] < 255)) m_cnt[n]++;
      end
    end
    last_pop = mp;
    @(posedge clk);
    #1;
    if (reset_L) begin
      for (int n = 0; n < 4; n++) begin
        if (last_pop[n]) begin
          din[n] = base[n] + DATA_W'(rd_idx[n]);
          rd_idx[n]++;
          if (rem[n] > 0) rem[n]--;
        end
      end
      cycle_no++;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int first_pop;
    int vbefore;
    int c1;

    reset_L = 1'b0;
    id      = '0;
    af      = 1'b0;
    force_e = '0;
    vcount  = 0;
    for (int n = 0; n < 4; n++) base[n] = DATA_W'(n * 16);
    model_reset();
    steps(3);

    // Reset release with all queues non-empty, id fixed at 0.
    for (int n = 0; n < 4; n++) rem[n] = 2;
    reset_L   = 1'b1;
    cycle_no  = 0;
    first_pop = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if ((first_pop < 0) && (last_dut_pop != 0)) begin
        first_pop = i;
        chk("first_pop_vec", last_dut_pop, 4'b0001);
      end
    end
    chk("first_pop_cycle", first_pop, INIT_CYCLES + 1);
    for (int n = 0; n < 4; n++) rem[n] = 0;
    steps(4);
    chk("t1_idle", idle, 1);

    // Queue 2 with three words, id fixed at 2.
    base[2] = 6'h11;
    rd_idx[2] = 0;
    rem[2] = 3;
    id = 2;
    seen_q.delete();
    steps(8);
    chk("t2_words", seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      chk("t2_w0", seen_q[0], 6'h11);
      chk("t2_w1", seen_q[1], 6'h12);
      chk("t2_w2", seen_q[2], 6'h13);
    end
    chk("t2_count2", pop_count[2*CNT_W +: CNT_W], 3);
    chk("t2_idle", idle, 1);

    // All queues non-empty, id cycling through 0..3.
    for (int n = 0; n < 4; n++) begin
      base[n] = DATA_W'(n * 16);
      rd_idx[n] = 0;
      rem[n] = 4;
    end
    for (int i = 0; i < 24; i++) begin
      id = 2'(i % 4);
      step();
    end
    steps(4);
    chk("t3_idle", idle, 1);

    // Back-pressure mid-stream on queue 1.
    rem[1] = 20;
    id = 1;
    steps(5);
    af = 1'b1;
    vbefore = vcount;
    steps(6);
    chk("t4_af_drain", vcount - vbefore, 2);
    af = 1'b0;
    steps(30);
    chk("t4_idle", idle, 1);

    // Selected queue empty while others hold data.
    for (int n = 0; n < 4; n++) rem[n] = 3;
    id = 0;
    steps(3);
    c1 = m_cnt[1];
    id = 1;
    force_e = 4'b0010;
    step();
    chk("t5_no_pop", last_dut_pop, 0);
    force_e = '0;
    id = 0;
    steps(2);
    chk("t5_count1", pop_count[1*CNT_W +: CNT_W], c1);
    for (int n = 0; n < 4; n++) rem[n] = 0;
    steps(4);
    chk("t5_idle", idle, 1);

    // Counter saturation on queue 3, then reset mid-stream.
    rem[3] = 300;
    id = 3;
    steps(303);
    chk("t6_sat", pop_count[3*CNT_W +: CNT_W], 255);
    rem[3] = 10;
    steps(4);
    chk("t6_pre_valid", valid_out, 1);
    reset_L = 1'b0;
    #1;
    chk("t6_rst_valid", valid_out, 0);
    chk("t6_rst_count", pop_count, 0);
    chk("t6_rst_pop", pop, 0);
    model_reset();
    steps(2);
    reset_L = 1'b1;
    cycle_no = 0;
    steps(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dequeue_mux.md
Name: dequeue_mux

Overview:
- Downstream stage of the round-robin arbiter.
- Takes the arbiter's queue id and the 4 FIFO empty flags, and pops the selected input FIFO.
- Muxes that FIFO's read data into one registered output stream toward the next-stage FIFO, honouring that FIFO's almost-full back-pressure.
- Keeps per-queue pop counters for bring-up and verification.

Parameters:
- DATA_W, 6, width of each queue data word.
- CNT_W, 8, width of each per-queue pop counter.
- INIT_CYCLES, 2, cycles held in INIT after reset release before any pop.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- id  input  2  queue selected by the arbiter this cycle.
- empty  input  4  empty flag per input FIFO, bit n = queue n.
- data_in0  input  DATA_W  read data, FIFO 0.
- data_in1  input  DATA_W  read data, FIFO 1.
- data_in2  input  DATA_W  read data, FIFO 2.
- data_in3  input  DATA_W  read data, FIFO 3.
- out_almost_full  input  1  back-pressure from the downstream FIFO.
- pop  output  4  one-hot read strobe to the input FIFOs.
- data_out  output  DATA_W  registered output word.
- valid_out  output  1  data_out is a new word this cycle (push to downstream).
- idle  output  1  block is in IDLE with nothing in flight.
- pop_count  output  4*CNT_W  per-queue pop counters; queue n at bits [n*CNT_W +: CNT_W].

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=INIT, init counter=0, pipeline regs cleared.
  - Outputs: pop=0, data_out=0, valid_out=0, idle=0, all pop_count=0.
- FSM states: INIT, IDLE, ACTIVE.
  - INIT: count INIT_CYCLES cycles, then go to IDLE. pop held 0.
  - IDLE: idle=1. Go to ACTIVE when any empty bit is 0.
  - ACTIVE: idle=0. Go to IDLE when empty==4'b1111 and both in-flight stages are clear.
- pop (combinational, cycle t): pop[id]=1 iff state==ACTIVE and empty[id]==0 and out_almost_full==0. All other pop bits are 0.
  - Never more than one bit set.
  - If empty[id]=1 while other queues are non-empty, no pop that cycle. The arbiter advances; no re-selection is done here.
- Input FIFO read data is valid the cycle after pop (t+1).
- Stage 1, edge ending t: sel_d<=id, pend_d<=|pop.
- Stage 2, edge ending t+1: data_out<=data_in[sel_d] when pend_d=1, else data_out holds. valid_out<=pend_d.
- Latency: pop at cycle t gives valid_out=1 in cycle t+2. Sustained throughput is 1 word/cycle.
- Back-pressure:
  - out_almost_full blocks new pops only. Up to 2 words already in flight still emerge.
  - The downstream almost-full threshold must leave at least 2 free entries.
- pop_count[n] increments on each cycle pop[n]=1. It saturates at all-ones and never wraps.
- Boundary cases:
  - empty[id] and out_almost_full both change in cycle t: pop uses their cycle-t values.
  - State goes to IDLE while a word is in flight: illegal. The IDLE exit condition already requires pend_d and valid_out clear.
  - Reset mid-stream: in-flight words are discarded and valid_out drops to 0 immediately. Input FIFOs are reset by the same reset_L.
  - id is don't-care outside ACTIVE.

Decomposition:
- Shared package:
  - state encoding constants: INIT=2'd0, IDLE=2'd1, ACTIVE=2'd2.
  - constant NUM_Q=4 and ID_W=2.
- Sub-module sat_counter (CNT_W wide, inc, saturating), instantiated 4 times for pop_count.
- Mux and FSM stay in the top module.

Test Plan:
- Reset release with INIT_CYCLES=2 and all queues non-empty, id=0 -> pop=0 for cycles 0-1 after release; INIT then IDLE, pop[0]=1 first in ACTIVE.
- Queue 2 holds 3 words (0x11,0x12,0x13), id fixed at 2, out_almost_full=0 -> pop=4'b0100 for 3 cycles; data_out=0x11,0x12,0x13 with valid_out=1 at t+2..t+4; pop_count[2]=3; then idle=1.
- All queues non-empty, id cycling 0,1,2,3 -> pop cycles 0001,0010,0100,1000; data_out order matches queue order with 2-cycle latency.
- out_almost_full rises in cycle t during a stream -> pop=0 from t; exactly 2 further valid_out pulses, then none until out_almost_full=0.
- id=1 with empty=4'b0010, other queues non-empty -> pop=0 that cycle, no valid_out two cycles later, pop_count unchanged.
- 300 pops on queue 3 with CNT_W=8 -> pop_count[3] holds 255. Then reset_L=0 mid-stream -> valid_out=0 and all counters=0 asynchronously.
